cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter s_line, default 256, the cache line width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_read, i_write  input  1 each  I-cache line read/write request.
REQ-005 SHALL have ports i_address  input  32  and i_wdata  input  s_line  for the I-cache request.
REQ-006 SHALL have ports i_rdata  output  s_line  and i_resp  output  1  for the I-cache response.
REQ-007 SHALL have ports d_read, d_write  input  1 each, d_address  input  32, d_wdata  input  s_line  for the D-cache request.
REQ-008 SHALL have ports d_rdata  output  s_line  and d_resp  output  1  for the D-cache response.
REQ-009 SHALL have ports pmem_read, pmem_write  output  1 each, pmem_address  output  32, pmem_wdata  output  s_line  toward the shared line memory.
REQ-010 SHALL have ports pmem_rdata  input  s_line  and pmem_resp  input  1  from the shared line memory.

Function
REQ-011 SHALL implement an FSM with states IDLE, SERVE_I, SERVE_D and RESP.
REQ-012 IDLE: any request from exactly one port SHALL cause a move to SERVE_I or SERVE_D at the next edge, capturing that port's address, wdata and operation.
REQ-013 Simultaneous I and D requests in IDLE SHALL be granted round-robin to the port not recorded in last_grant; last_grant SHALL update on every grant.
REQ-014 A port asserting read and write together SHALL be serviced as a write.
REQ-015 SERVE_x: pmem_read or pmem_write SHALL be held high with the captured address and wdata, stable every cycle, until pmem_resp.
REQ-016 Captured address, wdata and operation SHALL NOT change while in SERVE_x, regardless of requester input changes.
REQ-017 On pmem_resp in SERVE_x: pmem_rdata SHALL be registered, and the FSM SHALL enter RESP with pmem_read and pmem_write low.
REQ-018 RESP SHALL last exactly one cycle: the granted port's resp SHALL be high and its rdata SHALL equal the registered line; the FSM SHALL then return to IDLE.
REQ-019 Requests SHALL be ignored in RESP. A requester still asserting in IDLE after RESP SHALL be treated as a new request.
REQ-020 The ungranted port's resp SHALL stay low throughout; its rdata SHALL hold its last value.
REQ-021 Latency: a lone request sampled in IDLE at cycle t, with pmem_resp at cycle t+1+k, SHALL produce resp at cycle t+2+k.
REQ-022 pmem_resp arriving outside SERVE_x SHALL be ignored.

Reset
REQ-023 Reset asserted (rst=0) SHALL immediately force IDLE and last_grant=I, and drive all outputs to 0, including rdata registers, pmem_address and pmem_wdata.
REQ-024 Reset mid-transaction SHALL discard the transaction; no resp SHALL be issued for it after reset is released.
REQ-025 After rst rises, the first arbitration SHALL occur at the first clk edge sampled in IDLE.

Structure
REQ-026 The enum arb_state_t {IDLE, SERVE_I, SERVE_D, RESP} and the enum arb_port_t {PORT_I, PORT_D} SHALL be added to the shared cache_types package.
REQ-027 The block SHALL be a single module with no sub-modules; the FSM next-state logic, the capture registers and the output muxing live in it.

Verification
REQ-028 Lone I read of 0x0000_1040 with pmem_resp 3 cycles later, pmem_rdata=0xA5 repeated -> pmem_read high at 0x0000_1040 for 3 cycles; i_resp one cycle after pmem_resp with i_rdata=0xA5 repeated; d_resp stays 0.
REQ-029 I read and D write (0x0000_2000, wdata=0x1234 repeated) in the same cycle after reset -> D granted first (pmem_write, 0x0000_2000), then I; the next tie goes to D.
REQ-030 D toggles its address to 0xFFFF_FFE0 during SERVE_D -> pmem_address stays at the captured value until pmem_resp.
REQ-031 rst=0 for one cycle during SERVE_I, pmem_resp arriving afterward -> outputs 0 immediately, no i_resp, FSM idle.
REQ-032 D asserts d_read and d_write together -> pmem_write high, pmem_read low.
REQ-033 I holds i_read through its resp cycle -> a second pmem_read is issued starting the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/cache_types.sv
// Shared cache-side types: arbiter FSM states and requester identifiers.
package cache_types;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RESP
   } arb_state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } arb_port_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one line-memory port between the I-cache and D-cache, one
// transaction at a time, with round-robin on simultaneous requests.
//
// state   | meaning
// IDLE    | sample requests, grant one, capture its address/wdata/operation
// SERVE_I | I transaction held on pmem until pmem_resp
// SERVE_D | D transaction held on pmem until pmem_resp
// RESP    | one-cycle resp pulse to the granted cache, requests ignored
module cache_arbiter
   import cache_types::*;
#(
   parameter int s_line = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [31:0]       i_address,
   input  logic [s_line-1:0] i_wdata,
   output logic [s_line-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [s_line-1:0] d_wdata,
   output logic [s_line-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state;
   arb_port_t  last_grant;
   arb_port_t  grant;
   logic       i_req;
   logic       d_req;

   always_comb begin
      i_req = i_read | i_write;
      d_req = d_read | d_write;
      grant = PORT_I;
      if (i_req && d_req)
         grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
      else if (d_req)
         grant = PORT_D;
   end

   // pmem_address/pmem_wdata double as the capture registers, so they stay
   // frozen for the whole SERVE phase no matter what the requesters do.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= PORT_I;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         i_resp       <= 1'b0;
         d_resp       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  last_grant <= grant;
                  if (grant == PORT_I) begin
                     state        <= SERVE_I;
                     pmem_address <= i_address;
                     pmem_wdata   <= i_wdata;
                     pmem_write   <= i_write;
                     pmem_read    <= ~i_write;
                  end else begin
                     state        <= SERVE_D;
                     pmem_address <= d_address;
                     pmem_wdata   <= d_wdata;
                     pmem_write   <= d_write;
                     pmem_read    <= ~d_write;
                  end
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state      <= RESP;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  if (state == SERVE_I) begin
                     i_rdata <= pmem_rdata;
                     i_resp  <= 1'b1;
                  end else begin
                     d_rdata <= pmem_rdata;
                     d_resp  <= 1'b1;
                  end
               end
            end
            RESP: begin
               state  <= IDLE;
               i_resp <= 1'b0;
               d_resp <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a transaction scoreboard and a
// behavioural line memory that answers with a programmable delay.
module tb_cache_arbiter;
   import cache_types::*;

   localparam int SL = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_read = 1'b0, i_write = 1'b0;
   logic [31:0]   i_address = '0;
   logic [SL-1:0] i_wdata = '0;
   logic [SL-1:0] i_rdata;
   logic          i_resp;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [31:0]   d_address = '0;
   logic [SL-1:0] d_wdata = '0;
   logic [SL-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read, pmem_write;
   logic [31:0]   pmem_address;
   logic [SL-1:0] pmem_wdata;
   logic [SL-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;

   always #5 clk = ~clk;

   cache_arbiter #(.s_line(SL)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   typedef struct {
      arb_port_t     port;
      logic          wr;
      logic [31:0]   addr;
      logic [SL-1:0] wdata;
   } txn_t;

   txn_t          sbq[$];
   int            n_pass = 0;
   int            n_total = 0;
   logic [SL-1:0] i_hold = '0;
   logic [SL-1:0] d_hold = '0;
   arb_port_t     tb_last = PORT_I;
   int            waited;

   task automatic chk(input string tag, input logic [SL-1:0] obs, input logic [SL-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic txn_t mk(arb_port_t p, logic wr, logic [31:0] a, logic [SL-1:0] wd);
      txn_t t;
      t.port = p; t.wr = wr; t.addr = a; t.wdata = wd;
      return t;
   endfunction

   // Round-robin model: on a tie the port that did not win last goes first.
   task automatic push_tie(input txn_t ti, input txn_t td);
      if (tb_last == PORT_I) begin
         sbq.push_back(td); sbq.push_back(ti);
      end else begin
         sbq.push_back(ti); sbq.push_back(td);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_pmem_read", SL'(pmem_read), '0);
      chk("rst_pmem_write", SL'(pmem_write), '0);
      chk("rst_pmem_address", SL'(pmem_address), '0);
      chk("rst_pmem_wdata", pmem_wdata, '0);
      chk("rst_i_rdata", i_rdata, '0);
      chk("rst_d_rdata", d_rdata, '0);
      chk("rst_resp", SL'({i_resp, d_resp}), '0);
      i_hold = '0; d_hold = '0; tb_last = PORT_I;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at a negedge right after a request was driven: finds the grant,
   // checks pmem stays stable for 1+k cycles, returns the line, checks resp.
   task automatic serve(input int k, input logic [SL-1:0] rd, input bit hold, output int w);
      txn_t e;
      w = 0;
      if (sbq.size() == 0) begin
         chk("sb_underflow", SL'(1), '0);
         return;
      end
      e = sbq.pop_front();
      @(negedge clk);
      while (!(pmem_read || pmem_write) && w < 20) begin
         w++;
         @(negedge clk);
      end
      chk("grant_seen", SL'(pmem_read || pmem_write), SL'(1));
      tb_last = e.port;
      if (!hold) begin
         if (e.port == PORT_I) begin
            i_read = 1'b0; i_write = 1'b0;
            i_address = 32'hFFFF_FFE0; i_wdata = {8{$urandom}};
         end else begin
            d_read = 1'b0; d_write = 1'b0;
            d_address = 32'hFFFF_FFE0; d_wdata = {8{$urandom}};
         end
      end
      for (int c = 0; c <= k; c++) begin
         if (c > 0) @(negedge clk);
         chk("pmem_write", SL'(pmem_write), SL'(e.wr));
         chk("pmem_read", SL'(pmem_read), SL'(!e.wr));
         chk("pmem_address", SL'(pmem_address), SL'(e.addr));
         if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
         chk("resp_early", SL'({i_resp, d_resp}), '0);
      end
      pmem_resp = 1'b1;
      pmem_rdata = rd;
      @(negedge clk);
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      chk("pmem_idle_in_resp", SL'({pmem_read, pmem_write}), '0);
      if (e.port == PORT_I) begin
         chk("i_resp", SL'(i_resp), SL'(1));
         chk("i_rdata", i_rdata, rd);
         chk("d_resp_quiet", SL'(d_resp), '0);
         chk("d_rdata_hold", d_rdata, d_hold);
         i_hold = rd;
      end else begin
         chk("d_resp", SL'(d_resp), SL'(1));
         chk("d_rdata", d_rdata, rd);
         chk("i_resp_quiet", SL'(i_resp), '0);
         chk("i_rdata_hold", i_rdata, i_hold);
         d_hold = rd;
      end
      @(negedge clk);
      chk("resp_one_cycle", SL'({i_resp, d_resp}), '0);
      chk("pmem_idle_after", SL'({pmem_read, pmem_write}), '0);
   endtask

   initial begin
      do_reset();

      // lone I read, memory answers 3 cycles after the request is sampled
      i_read = 1'b1; i_address = 32'h0000_1040;
      sbq.push_back(mk(PORT_I, 1'b0, 32'h0000_1040, '0));
      serve(2, {32{8'hA5}}, 1'b0, waited);
      chk("lat_lone", SL'(waited), '0);

      // stray pmem_resp in IDLE
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      chk("stray_resp", SL'({i_resp, d_resp, pmem_read, pmem_write}), '0);
      @(negedge clk);
      chk("stray_resp2", SL'({i_resp, d_resp, pmem_read, pmem_write}), '0);

      // two ties after reset: D, I, then D, I
      do_reset();
      for (int r = 0; r < 2; r++) begin
         i_read = 1'b1; i_address = 32'h0000_5000 + 32'(r * 32'h100);
         d_write = 1'b1; d_address = 32'h0000_2000 + 32'(r * 32'h100);
         d_wdata = {16{16'h1234}};
         push_tie(mk(PORT_I, 1'b0, i_address, '0), mk(PORT_D, 1'b1, d_address, d_wdata));
         serve(1, {8{32'h1111_0000 + 32'(r)}}, 1'b0, waited);
         serve(1, {8{32'h2222_0000 + 32'(r)}}, 1'b0, waited);
      end

      // D read; its address is scrambled to FFFF_FFE0 inside serve
      d_read = 1'b1; d_address = 32'h0000_3000;
      sbq.push_back(mk(PORT_D, 1'b0, 32'h0000_3000, '0));
      serve(3, {8{32'hCAFE_0003}}, 1'b0, waited);

      // read+write together is a write
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_6000;
      d_wdata = {8{32'h0BAD_F00D}};
      sbq.push_back(mk(PORT_D, 1'b1, 32'h0000_6000, {8{32'h0BAD_F00D}}));
      serve(0, {8{32'h0000_6006}}, 1'b0, waited);

      // I holds its request through resp: re-issued right after IDLE
      i_read = 1'b1; i_address = 32'h0000_7000;
      sbq.push_back(mk(PORT_I, 1'b0, 32'h0000_7000, '0));
      serve(1, {8{32'h7777_0001}}, 1'b1, waited);
      sbq.push_back(mk(PORT_I, 1'b0, 32'h0000_7000, '0));
      serve(1, {8{32'h7777_0002}}, 1'b0, waited);
      chk("rerequest_latency", SL'(waited), '0);

      // reset mid-transaction discards it
      i_read = 1'b1; i_address = 32'h0000_4000;
      @(negedge clk);
      chk("mid_serving", SL'(pmem_read), SL'(1));
      i_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_pmem", SL'({pmem_read, pmem_write}), '0);
      chk("mid_rst_addr", SL'(pmem_address), '0);
      chk("mid_rst_i_rdata", i_rdata, '0);
      chk("mid_rst_d_rdata", d_rdata, '0);
      @(negedge clk);
      rst = 1'b1;
      pmem_resp = 1'b1;
      pmem_rdata = {8{32'hDEAD_BEEF}};
      @(negedge clk);
      pmem_resp = 1'b0;
      chk("mid_no_resp", SL'({i_resp, d_resp, pmem_read}), '0);
      @(negedge clk);
      chk("mid_no_resp2", SL'({i_resp, d_resp, pmem_read}), '0);
      chk("mid_i_rdata", i_rdata, '0);

      chk("sb_empty", SL'(sbq.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
